// File: rtl/cadder_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cadder_checker: compares a 4-bit adder's Z against A+B over a counted run.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cadder_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  input  logic [4:0]       Z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       first_err_a,
  output logic [3:0]       first_err_b,
  output logic [4:0]       first_err_z,
  output logic             first_err_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] checked_q, checked_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fe_valid_q, fe_valid_d;
  logic [3:0]       fe_a_q, fe_a_d;
  logic [3:0]       fe_b_q, fe_b_d;
  logic [4:0]       fe_z_q, fe_z_d;

  logic [LATENCY-1:0]      dl_v_q, dl_v_d;
  logic [LATENCY-1:0][3:0] dl_a_q, dl_a_d;
  logic [LATENCY-1:0][3:0] dl_b_q, dl_b_d;

  logic       accept;
  logic       cmp_v;
  logic [4:0] exp_sum;
  logic       mismatch;

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    issued_d   = issued_q;
    checked_d  = checked_q;
    err_d      = err_q;
    pass_d     = pass_q;
    fe_valid_d = fe_valid_q;
    fe_a_d     = fe_a_q;
    fe_b_d     = fe_b_q;
    fe_z_d     = fe_z_q;

    accept = (state_q == RUN) && in_valid && (issued_q < num_q);

    // Delay line mirrors the adder pipeline so Z lines up with its operands
    dl_v_d[0] = accept;
    dl_a_d[0] = A;
    dl_b_d[0] = B;
    for (int i = 1; i < LATENCY; i++) begin
      dl_v_d[i] = dl_v_q[i-1];
      dl_a_d[i] = dl_a_q[i-1];
      dl_b_d[i] = dl_b_q[i-1];
    end

    cmp_v    = dl_v_q[LATENCY-1];
    exp_sum  = {1'b0, dl_a_q[LATENCY-1]} + {1'b0, dl_b_q[LATENCY-1]};
    mismatch = cmp_v && (Z != exp_sum);

    if (cmp_v) begin
      checked_d = checked_q + CNT_W'(1);
    end
    if (mismatch) begin
      if (err_q != {CNT_W{1'b1}}) begin
        err_d = err_q + CNT_W'(1);
      end
      if (!fe_valid_q) begin
        fe_valid_d = 1'b1;
        fe_a_d     = dl_a_q[LATENCY-1];
        fe_b_d     = dl_b_q[LATENCY-1];
        fe_z_d     = Z;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          num_d      = num_vec;
          issued_d   = '0;
          checked_d  = '0;
          err_d      = '0;
          pass_d     = 1'b0;
          fe_valid_d = 1'b0;
          fe_a_d     = '0;
          fe_b_d     = '0;
          fe_z_d     = '0;
          state_d    = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          issued_d = issued_q + CNT_W'(1);
        end
        if (issued_q == num_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (checked_q == num_q) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    if (state_d == DONE) begin
      pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      num_q      <= '0;
      issued_q   <= '0;
      checked_q  <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fe_valid_q <= 1'b0;
      fe_a_q     <= '0;
      fe_b_q     <= '0;
      fe_z_q     <= '0;
      dl_v_q     <= '0;
      dl_a_q     <= '0;
      dl_b_q     <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      checked_q  <= checked_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fe_valid_q <= fe_valid_d;
      fe_a_q     <= fe_a_d;
      fe_b_q     <= fe_b_d;
      fe_z_q     <= fe_z_d;
      dl_v_q     <= dl_v_d;
      dl_a_q     <= dl_a_d;
      dl_b_q     <= dl_b_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign checked_cnt     = checked_q;
  assign err_cnt         = err_q;
  assign first_err_a     = fe_a_q;
  assign first_err_b     = fe_b_q;
  assign first_err_z     = fe_z_q;
  assign first_err_valid = fe_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cadder_checker.sv
`default_nettype none
// Bench for cadder_checker: two instances (LATENCY 1 and 3) checked every
// cycle against a run-level model, plus hand-computed literal expectations.
module tb_cadder_checker;

  logic clk;
  logic rst_n;

  logic        st [2];
  logic [15:0] nv [2];
  logic        iv [2];
  logic [3:0]  ia [2];
  logic [3:0]  ib [2];
  logic [4:0]  iz [2];

  logic [1:0]  busy_w, done_w, pass_w, fev_w;
  logic [15:0] chk_w [2];
  logic [15:0] err_w [2];
  logic [3:0]  fa_w [2];
  logic [3:0]  fb_w [2];
  logic [4:0]  fz_w [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  cadder_checker #(.LATENCY(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .num_vec(nv[0]), .in_valid(iv[0]),
    .A(ia[0]), .B(ib[0]), .Z(iz[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .checked_cnt(chk_w[0]), .err_cnt(err_w[0]),
    .first_err_a(fa_w[0]), .first_err_b(fb_w[0]), .first_err_z(fz_w[0]),
    .first_err_valid(fev_w[0])
  );

  cadder_checker #(.LATENCY(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .num_vec(nv[1]), .in_valid(iv[1]),
    .A(ia[1]), .B(ib[1]), .Z(iz[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .checked_cnt(chk_w[1]), .err_cnt(err_w[1]),
    .first_err_a(fa_w[1]), .first_err_b(fb_w[1]), .first_err_z(fz_w[1]),
    .first_err_valid(fev_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Run-level model: phase 0 idle, 1 running, 2 draining, 3 done
  int          m_ph  [2];
  int          m_e   [2];
  int          m_num [2];
  int          m_iss [2];
  int          m_chk [2];
  int          m_err [2];
  bit          m_pass[2];
  bit          m_fev [2];
  int          m_fa  [2];
  int          m_fb  [2];
  int          m_fz  [2];
  bit          hv [2][8];
  int          ha [2][8];
  int          hb [2][8];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_e[k] = 0; m_num[k] = 0; m_iss[k] = 0; m_chk[k] = 0;
      m_err[k] = 0; m_pass[k] = 0; m_fev[k] = 0; m_fa[k] = 0; m_fb[k] = 0; m_fz[k] = 0;
      for (int j = 0; j < 8; j++) begin
        hv[k][j] = 0; ha[k][j] = 0; hb[k][j] = 0;
      end
    end
  endtask

  task automatic model_step(input int k);
    int lat, ri, wi, p_iss, p_chk;
    bit acc;
    lat   = (k == 0) ? 1 : 3;
    ri    = (m_e[k] + 8 - lat) % 8;
    wi    = m_e[k] % 8;
    p_iss = m_iss[k];
    p_chk = m_chk[k];
    acc   = (m_ph[k] == 1) && iv[k] && (m_iss[k] < m_num[k]);
    // Z seen now belongs to the operands accepted LATENCY edges ago
    if (hv[k][ri]) begin
      m_chk[k] = m_chk[k] + 1;
      if (int'(iz[k]) != ha[k][ri] + hb[k][ri]) begin
        if (m_err[k] < 65535) m_err[k] = m_err[k] + 1;
        if (!m_fev[k]) begin
          m_fev[k] = 1; m_fa[k] = ha[k][ri]; m_fb[k] = hb[k][ri]; m_fz[k] = int'(iz[k]);
        end
      end
    end
    hv[k][wi] = acc; ha[k][wi] = int'(ia[k]); hb[k][wi] = int'(ib[k]);
    case (m_ph[k])
      0: if (st[k]) begin
        m_num[k] = int'(nv[k]); m_iss[k] = 0; m_chk[k] = 0; m_err[k] = 0; m_pass[k] = 0;
        m_fev[k] = 0; m_fa[k] = 0; m_fb[k] = 0; m_fz[k] = 0;
        m_ph[k] = (nv[k] == 16'd0) ? 3 : 1;
      end
      1: begin
        if (acc) m_iss[k] = m_iss[k] + 1;
        if (p_iss == m_num[k]) m_ph[k] = 2;
      end
      2: if (p_chk == m_num[k]) m_ph[k] = 3;
      default: m_ph[k] = 0;
    endcase
    if (m_ph[k] == 3) m_pass[k] = (m_err[k] == 0);
    m_e[k] = m_e[k] + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  function automatic logic [48:0] act_vec(input int k);
    return {busy_w[k], done_w[k], pass_w[k], fev_w[k], fa_w[k], fb_w[k], fz_w[k], chk_w[k], err_w[k]};
  endfunction

  function automatic logic [48:0] exp_vec(input int k);
    return {(m_ph[k] == 1 || m_ph[k] == 2), (m_ph[k] == 3), m_pass[k], m_fev[k],
            4'(m_fa[k]), 4'(m_fb[k]), 5'(m_fz[k]), 16'(m_chk[k]), 16'(m_err[k])};
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        n_cmp = n_cmp + 1;
        if (act_vec(k) !== exp_vec(k)) begin
          n_bad = n_bad + 1;
          $display("FAIL model_cmp inst%0d t=%0t {busy,done,pass,fev,a,b,z,chk,err} got %h want %h",
                   k, $time, act_vec(k), exp_vec(k));
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int k, input bit s, input int n, input bit v,
                      input int a, input int b, input int z);
    for (int j = 0; j < 2; j++) begin
      st[j] = 1'b0; nv[j] = '0; iv[j] = 1'b0; ia[j] = '0; ib[j] = '0; iz[j] = '0;
    end
    st[k] = s; nv[k] = 16'(n); iv[k] = v; ia[k] = 4'(a); ib[k] = 4'(b); iz[k] = 5'(z);
    @(negedge clk);
  endtask

  task automatic wait_done(input int k, output int dc);
    bit seen;
    seen = 0;
    dc = -1;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done_w[k]) begin
        seen = 1;
        dc = cyc;
      end else begin
        step(k, 0, 0, 0, 0, 0, 0);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  int t0, dc;

  initial begin
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      st[j] = 1'b0; nv[j] = '0; iv[j] = 1'b0; ia[j] = '0; ib[j] = '0; iz[j] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs_l1", int'(act_vec(0) != '0), 0);
    chk("reset_outputs_l3", int'(act_vec(1) != '0), 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);

    // Clean run, LATENCY 1
    t0 = cyc;
    step(0, 1, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 4, 0);
    step(0, 0, 0, 1, 15, 15, 7);
    step(0, 0, 0, 1, 0, 0, 30);
    step(0, 0, 0, 1, 8, 9, 0);
    step(0, 0, 0, 0, 0, 0, 17);
    wait_done(0, dc);
    chk("clean_done_cycle", dc - t0, 7);
    chk("clean_checked", int'(chk_w[0]), 4);
    chk("clean_err", int'(err_w[0]), 0);
    chk("clean_pass", int'(pass_w[0]), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("clean_pass_held", int'(pass_w[0]), 1);

    // Carry error on (15,15)
    step(0, 1, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 4, 0);
    step(0, 0, 0, 1, 15, 15, 7);
    step(0, 0, 0, 1, 0, 0, 14);
    step(0, 0, 0, 1, 8, 9, 0);
    step(0, 0, 0, 0, 0, 0, 17);
    wait_done(0, dc);
    chk("carry_err", int'(err_w[0]), 1);
    chk("carry_first", int'({fa_w[0], fb_w[0], fz_w[0]}), int'({4'd15, 4'd15, 5'd14}));
    chk("carry_fev", int'(fev_w[0]), 1);
    chk("carry_pass", int'(pass_w[0]), 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Zero-length run
    t0 = cyc;
    step(0, 1, 0, 0, 0, 0, 0);
    chk("zero_done_cycle", cyc - t0, 1);
    chk("zero_done", int'(done_w[0]), 1);
    chk("zero_pass", int'(pass_w[0]), 1);
    chk("zero_checked", int'(chk_w[0]), 0);
    chk("zero_busy", int'(busy_w[0]), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("zero_done_pulse", int'(done_w[0]), 0);

    // LATENCY 3: gaps, two extra vectors, two mismatches
    t0 = cyc;
    step(1, 1, 3, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 2, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 5, 6, 0);
    step(1, 0, 0, 0, 0, 0, 3);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 9, 9, 10);
    step(1, 0, 0, 1, 7, 7, 0);
    step(1, 0, 0, 1, 2, 2, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    wait_done(1, dc);
    chk("gaps_done_cycle", dc - t0, 11);
    chk("gaps_checked", int'(chk_w[1]), 3);
    chk("gaps_err", int'(err_w[1]), 2);
    chk("gaps_first", int'({fa_w[1], fb_w[1], fz_w[1]}), int'({4'd5, 4'd6, 5'd10}));
    chk("gaps_pass", int'(pass_w[1]), 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Start while busy is ignored; reset mid-run clears everything at once
    step(0, 1, 4, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 2, 2, 2);
    chk("midrun_busy", int'(busy_w[0]), 1);
    chk("midrun_checked", int'(chk_w[0]), 1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", int'(act_vec(0) != '0), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_idle", int'(busy_w[0]), 0);
    t0 = cyc;
    step(0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4, 5, 0);
    step(0, 0, 0, 1, 6, 7, 9);
    step(0, 0, 0, 0, 0, 0, 13);
    wait_done(0, dc);
    chk("rerun_done_cycle", dc - t0, 5);
    chk("rerun_checked", int'(chk_w[0]), 2);
    chk("rerun_pass", int'(pass_w[0]), 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
